stream_downsizer: RTL and testbench

- Downstream neighbour of the 32-bit valid/ready pipeline register.
- Accepts one IN_WIDTH word per handshake and emits it as RATIO = IN_WIDTH/OUT_WIDTH narrower beats on a valid/ready output.
- Used where the register stage feeds a byte-wide sink (serializer, byte FIFO, UART/SPI TX path).
- Full-throughput: back-to-back words produce a continuous beat stream with no bubble.

---
 rtl/stream_pkg.sv | 19 +
 rtl/stream_downsizer.sv | 101 ++++++++++
 tb/tb_stream_downsizer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared widths, FSM state type and counter-width helper for the stream width converters.
package stream_pkg;

  localparam int STREAM_WORD_W = 32;
  localparam int STREAM_BYTE_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } stream_state_e;

  // A single-beat ratio would still need one flop, so never return zero.
  function automatic int cnt_width(input int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Splits each IN_WIDTH word into RATIO OUT_WIDTH beats on a valid/ready stream.
// Define STREAM_DOWNSIZER_MSB_FIRST_EN to emit the most-significant slice first.
//
//   state | meaning
//   EMPTY | no word held, in_ready=1
//   SEND  | word held in data_q, slice beat_q presented on out_*
module stream_downsizer
  import stream_pkg::*;
#(
  parameter int IN_WIDTH  = STREAM_WORD_W,
  parameter int OUT_WIDTH = STREAM_BYTE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = cnt_width(RATIO);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_params
    $fatal(1, "stream_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
  end

  stream_state_e        state_q, state_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [IN_WIDTH-1:0]  data_q, data_d;
  logic                 at_last;

  assign at_last   = (beat_q == LAST_BEAT);
  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && at_last;
  // Combinational through out_ready so the next word lands on the final beat with no bubble.
  assign in_ready  = (state_q == EMPTY) || (out_ready && at_last);

  always_comb begin
    out_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (beat_q == CNT_W'(k)) begin
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
        out_data = data_q[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
`else
        out_data = data_q[k*OUT_WIDTH +: OUT_WIDTH];
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          data_d  = in_data;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (at_last) begin
            beat_d = '0;
            if (in_valid) begin
              data_d = in_data;
            end else begin
              state_d = EMPTY;
            end
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = EMPTY;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      beat_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer: directed cases plus a random-stall run against a beat-queue model.
module tb_stream_downsizer;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int R  = IW / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;

  stream_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [OW-1:0] b;
  } beat_t;

  beat_t         exp_q[$];
  logic [OW-1:0] got_q[$];
  logic [IW-1:0] acc_q[$];
  int            n_total = 0;
  int            n_pass  = 0;
  int            n_acc   = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_byte  = '0;

  function automatic logic [OW-1:0] slice_of(input logic [IW-1:0] w, input int k);
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
    return OW'(w >> (OW * (R - 1 - k)));
`else
    return OW'(w >> (OW * k));
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Drive one cycle's inputs just after a falling edge, check against the model, advance the model.
  task automatic cycle(input logic iv, input logic [IW-1:0] d, input logic ordy);
    logic ev, er;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    ev = (exp_q.size() != 0);
    er = !ev || (ordy && exp_q.size() == 1);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, er);
    if (ev) begin
      chk("out_data", out_data, exp_q[0].b);
      chk("out_last", out_last, exp_q[0].last);
    end else begin
      chk("out_last_idle", out_last, 1'b0);
    end
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, prev_byte);
    end
    if (out_valid && out_ready) got_q.push_back(out_data);
    prev_stall = ev && !ordy;
    prev_byte  = ev ? exp_q[0].b : '0;
    if (ev && ordy) void'(exp_q.pop_front());
    if (iv && er) begin
      for (int k = 0; k < R; k++) exp_q.push_back('{last: (k == R - 1), b: slice_of(d, k)});
      acc_q.push_back(d);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic check_got(input string tag, input logic [IW-1:0] w0, input logic [IW-1:0] w1,
                           input int nwords);
    chk({tag, "_count"}, got_q.size(), nwords * R);
    for (int i = 0; i < nwords * R && i < got_q.size(); i++)
      chk(tag, got_q[i], slice_of((i < R) ? w0 : w1, i % R));
    got_q.delete();
  endtask

  // Reset with a pending handshake on both sides; reset must win.
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = $urandom;
    out_ready = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    got_q.delete();
    prev_stall = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, '0);
  endtask

  initial begin
    int budget;
    int nbad;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // Literal byte order for the first word.
    cycle(1'b1, 32'hDEADBEEF, 1'b1);
    repeat (R) cycle(1'b0, 32'h0, 1'b1);
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
    chk("msb_b0", got_q[0], 8'hDE);
    chk("msb_b3", got_q[3], 8'hEF);
`else
    chk("lsb_b0", got_q[0], 8'hEF);
    chk("lsb_b3", got_q[3], 8'hDE);
`endif
    check_got("basic", 32'hDEADBEEF, 32'h0, 1);

    // Back-to-back: second word offered while the first drains.
    cycle(1'b1, 32'hDEADBEEF, 1'b1);
    repeat (R) cycle(1'b1, 32'hCAFEBABE, 1'b1);
    repeat (R) cycle(1'b0, 32'h0, 1'b1);
    chk("b2b_words", n_acc, 3);
    check_got("b2b", 32'hDEADBEEF, 32'hCAFEBABE, 2);

    // Backpressure on the first beat.
    cycle(1'b1, 32'hCAFEBABE, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    repeat (R) cycle(1'b0, 32'h0, 1'b1);
    check_got("bp", 32'hCAFEBABE, 32'h0, 1);

    // Reset mid-word discards the remainder.
    cycle(1'b1, 32'h11223344, 1'b1);
    repeat (2) cycle(1'b0, 32'h0, 1'b1);
    do_reset();
    cycle(1'b1, 32'hAABBCCDD, 1'b1);
    repeat (R + 2) cycle(1'b0, 32'h0, 1'b1);
    check_got("post_rst", 32'hAABBCCDD, 32'h0, 1);

    // Random words with random stalls.
    acc_q.delete();
    n_acc  = 0;
    budget = 3000;
    while (n_acc < 64 && budget > 0) begin
      cycle(($urandom_range(0, 9) < 7), $urandom, $urandom_range(0, 1));
      budget--;
    end
    chk("rand_budget", (n_acc >= 64), 1'b1);
    budget = 4 * R;
    while (exp_q.size() != 0 && budget > 0) begin
      cycle(1'b0, 32'h0, 1'b1);
      budget--;
    end
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_count", got_q.size(), acc_q.size() * R);
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < acc_q.size() * R; i++)
      if (got_q[i] !== slice_of(acc_q[i / R], i % R)) nbad++;
    chk("rand_stream", nbad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
